// File: rtl/seq_mem_rf_nr_nw_fw_pkg.sv
// Shared helpers for the parametrised multi-ported register file:
// derived address width and packed-port slice arithmetic.
package rf_pkg;

  function automatic int addr_bits(input int nentries);
    return (nentries <= 1) ? 1 : $clog2(nentries);
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/seq_mem_rf_nr_nw_fw_fwd_mux.sv
// Per-read-port word select: the highest enabled write port hitting the
// read address wins, else the stored word; out-of-range reads give zero.
module rf_fwd_mux
  import rf_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int NENTRIES = 8,
  parameter int NWRITE   = 2,
  parameter int FORWARD  = 1,
  parameter int ABITS    = 3
) (
  input  logic [ABITS-1:0]        read_addr,
  input  logic [NBITS-1:0]        stored_data,
  input  logic [NWRITE-1:0]       write_en,
  input  logic [NWRITE*ABITS-1:0] write_addr,
  input  logic [NWRITE*NBITS-1:0] write_data,
  output logic [NBITS-1:0]        read_data
);

  always_comb begin
    read_data = '0;
    if (int'(read_addr) < NENTRIES) begin
      read_data = stored_data;
      if (FORWARD != 0) begin
        // Ascending scan so the last hit, i.e. the highest port index, wins.
        for (int j = 0; j < NWRITE; j++) begin
          if (write_en[j] && (write_addr[slice_lo(j, ABITS) +: ABITS] == read_addr)) begin
            read_data = write_data[slice_lo(j, NBITS) +: NBITS];
          end
        end
      end
    end
  end

endmodule

// File: rtl/seq_mem_rf_nr_nw_fw.sv
// Multi-ported register file: NREAD read / NWRITE write ports, optional
// write-to-read forwarding and optional one-cycle registered read data.
module seq_mem_rf_nr_nw_fw
  import rf_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int NENTRIES = 8,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int FORWARD  = 1,
  parameter int REG_READ = 0,
  parameter int ABITS    = addr_bits(NENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREAD*ABITS-1:0]  read_addr,
  output logic [NREAD*NBITS-1:0]  read_data,
  input  logic [NWRITE-1:0]       write_en,
  input  logic [NWRITE*ABITS-1:0] write_addr,
  input  logic [NWRITE*NBITS-1:0] write_data
);

  logic [NBITS-1:0]       mem_q [NENTRIES];
  logic [NBITS-1:0]       mem_d [NENTRIES];
  logic [NREAD*NBITS-1:0] comb_data;

  // Later ports overwrite earlier ones, giving highest-index priority on conflicts.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (write_en[j] && (int'(write_addr[slice_lo(j, ABITS) +: ABITS]) < NENTRIES)) begin
        mem_d[write_addr[slice_lo(j, ABITS) +: ABITS]] = write_data[slice_lo(j, NBITS) +: NBITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NENTRIES; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [ABITS-1:0] addr;
    logic [NBITS-1:0] stored;

    assign addr   = read_addr[slice_lo(i, ABITS) +: ABITS];
    assign stored = (int'(addr) < NENTRIES) ? mem_q[addr] : '0;

    rf_fwd_mux #(
      .NBITS    (NBITS),
      .NENTRIES (NENTRIES),
      .NWRITE   (NWRITE),
      .FORWARD  (FORWARD),
      .ABITS    (ABITS)
    ) u_fwd_mux (
      .read_addr   (addr),
      .stored_data (stored),
      .write_en    (write_en),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .read_data   (comb_data[slice_lo(i, NBITS) +: NBITS])
    );
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NREAD*NBITS-1:0] rd_q;
    logic [NREAD*NBITS-1:0] rd_d;

    always_comb begin
      rd_d = comb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign read_data = rd_q;
  end else begin : g_comb_read
    // Forwarded write data must not leak out while reset is held.
    assign read_data = reset_n ? comb_data : '0;
  end

endmodule

// File: tb/tb_seq_mem_rf_nr_nw_fw.sv
// Self-checking bench: four register-file configurations share one stimulus
// bus and are compared against directed vectors and a behavioural model.
module tb_seq_mem_rf_nr_nw_fw;

  localparam int NB = 8;
  localparam int AB = 3;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR*AB-1:0] read_addr;
  logic [NW-1:0]    write_en;
  logic [NW*AB-1:0] write_addr;
  logic [NW*NB-1:0] write_data;
  logic [NR*NB-1:0] rd_a, rd_b, rd_c, rd_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: defaults, b: no forwarding, c: registered read, d: 6 entries
  seq_mem_rf_nr_nw_fw #(.NBITS(NB), .NENTRIES(8), .NREAD(NR), .NWRITE(NW), .FORWARD(1), .REG_READ(0)) u_a (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_a),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data));
  seq_mem_rf_nr_nw_fw #(.NBITS(NB), .NENTRIES(8), .NREAD(NR), .NWRITE(NW), .FORWARD(0), .REG_READ(0)) u_b (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_b),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data));
  seq_mem_rf_nr_nw_fw #(.NBITS(NB), .NENTRIES(8), .NREAD(NR), .NWRITE(NW), .FORWARD(1), .REG_READ(1)) u_c (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_c),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data));
  seq_mem_rf_nr_nw_fw #(.NBITS(NB), .NENTRIES(6), .NREAD(NR), .NWRITE(NW), .FORWARD(1), .REG_READ(0)) u_d (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_data(rd_d),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data));

  typedef struct {
    logic [1:0]  en;
    logic [2:0]  wa0;
    logic [7:0]  wd0;
    logic [2:0]  wa1;
    logic [7:0]  wd1;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_c;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [11];

  // Reference model: one plain array per configuration, plus the captured word of c.
  logic [7:0]  mem_m [4][8];
  logic [15:0] reg_m;

  function automatic int cfg_entries(input int k);
    return (k == 3) ? 6 : 8;
  endfunction

  function automatic bit cfg_forward(input int k);
    return (k != 1);
  endfunction

  function automatic logic [7:0] model_read(input int k, input int port);
    logic [2:0] a;
    logic [7:0] v;
    a = read_addr[port*AB +: AB];
    if (int'(a) >= cfg_entries(k)) return 8'h00;
    v = mem_m[k][a];
    if (cfg_forward(k)) begin
      for (int j = 0; j < NW; j++) begin
        if (write_en[j] && write_addr[j*AB +: AB] == a) v = write_data[j*NB +: NB];
      end
    end
    return v;
  endfunction

  function automatic logic [15:0] model_word(input int k);
    return {model_read(k, 1), model_read(k, 0)};
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 8; e++) mem_m[k][e] = 8'h00;
    end
    reg_m = 16'h0000;
  endfunction

  function automatic void model_clock();
    reg_m = model_word(2);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NW; j++) begin
        if (write_en[j] && int'(write_addr[j*AB +: AB]) < cfg_entries(k))
          mem_m[k][write_addr[j*AB +: AB]] = write_data[j*NB +: NB];
      end
    end
  endfunction

  task automatic applyStimulus(input logic [1:0] en, input logic [2:0] wa0, input logic [7:0] wd0,
                               input logic [2:0] wa1, input logic [7:0] wd1,
                               input logic [2:0] ra0, input logic [2:0] ra1);
    write_en   = en;
    write_addr = {wa1, wa0};
    write_data = {wd1, wd0};
    read_addr  = {ra1, ra0};
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                          input logic [15:0] ec, input logic [15:0] ed);
    checkOutput({tag, "/a"}, rd_a, ea);
    checkOutput({tag, "/b"}, rd_b, eb);
    checkOutput({tag, "/c"}, rd_c, ec);
    checkOutput({tag, "/d"}, rd_d, ed);
  endtask

  initial begin
    vecs[0]  = '{2'b11, 3'd1, 8'h23, 3'd2, 8'h45, 3'd1, 3'd2, 16'h4523, 16'h0000, 16'h0000, 16'h4523};
    vecs[1]  = '{2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd1, 3'd2, 16'h4523, 16'h4523, 16'h4523, 16'h4523};
    vecs[2]  = '{2'b11, 3'd5, 8'h11, 3'd5, 8'h22, 3'd5, 3'd5, 16'h2222, 16'h0000, 16'h4523, 16'h2222};
    vecs[3]  = '{2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd5, 3'd1, 16'h2322, 16'h2322, 16'h2222, 16'h2322};
    vecs[4]  = '{2'b01, 3'd4, 8'h89, 3'd0, 8'h77, 3'd4, 3'd5, 16'h2289, 16'h2200, 16'h2322, 16'h2289};
    vecs[5]  = '{2'b01, 3'd4, 8'hcd, 3'd0, 8'h77, 3'd4, 3'd4, 16'hcdcd, 16'h8989, 16'h2289, 16'hcdcd};
    vecs[6]  = '{2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd4, 3'd4, 16'hcdcd, 16'hcdcd, 16'hcdcd, 16'hcdcd};
    vecs[7]  = '{2'b10, 3'd0, 8'h77, 3'd6, 8'hef, 3'd6, 3'd3, 16'h00ef, 16'h0000, 16'hcdcd, 16'h0000};
    vecs[8]  = '{2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd6, 3'd7, 16'h00ef, 16'h00ef, 16'h00ef, 16'h0000};
    vecs[9]  = '{2'b01, 3'd7, 8'hff, 3'd0, 8'h77, 3'd7, 3'd7, 16'hffff, 16'h0000, 16'h00ef, 16'h0000};
    vecs[10] = '{2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd7, 3'd0, 16'h00ff, 16'h00ff, 16'hffff, 16'h0000};

    reset_n = 1'b0;
    applyStimulus(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_hold", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    model_clock();
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].en, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1, vecs[i].ra0, vecs[i].ra1);
      #3;
      checkAll($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c, vecs[i].exp_d);
      model_clock();
      @(posedge clk);
      #1;
    end

    // Mid-cycle reset: stored data disappears at once and held writes never land.
    applyStimulus(2'b01, 3'd3, 8'hab, 3'd0, 8'h77, 3'd3, 3'd3);
    #3;
    checkOutput("rst_write_fwd/a", rd_a, 16'habab);
    model_clock();
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd3, 3'd3);
    #3;
    checkOutput("rst_before/a", rd_a, 16'habab);
    reset_n = 1'b0;
    #1;
    checkAll("rst_async", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    model_clear();
    applyStimulus(2'b01, 3'd3, 8'hab, 3'd0, 8'h77, 3'd3, 3'd3);
    @(posedge clk);
    #1;
    checkAll("rst_write_ignored", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(2'b00, 3'd0, 8'h77, 3'd0, 8'h77, 3'd3, 3'd3);
    @(negedge clk);
    reset_n = 1'b1;
    model_clock();
    @(posedge clk);
    #1;
    checkAll("rst_release", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom),
                    3'($urandom_range(0, 7)), 8'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #3;
      checkAll($sformatf("rand%0d", i), model_word(0), model_word(1), reg_m, model_word(3));
      model_clock();
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
